uart_cfg: RTL and testbench

Parametrised full-duplex UART and successor to the fixed 8N1 uart block.
- Configurable divisor, data width (5..8), parity (none/even/odd) and stop bits (1/2).
- RX has an input synchroniser, start-bit glitch rejection, and parity and framing error flags.
- TX uses a level valid/busy handshake instead of edge detection.
- Sits between host logic (CPU bus, ESP8266 bridge) and the serial pins.

---
 rtl/uart_cfg_pkg.sv | 38 +++
 rtl/uart_cfg_if.sv | 23 ++
 rtl/uart_cfg_rx.sv | 144 ++++++++++++++
 rtl/uart_cfg.sv | 157 +++++++++++++++
 tb/tb_uart_cfg.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared types and helpers for the configurable UART.
package uart_cfg_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per serial bit.
  function automatic int divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Parity bit for a zero-extended data word (zero padding does not change XOR).
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    if (mode == PAR_ODD) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// Host-side handshake bundle: received-frame outputs and transmit request.
interface uart_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_send;
  logic                 tx_busy;
  logic                 tx_ready;

  modport master (
    input  rx_ready, rx_byte, rx_parity_err, rx_frame_err, tx_busy, tx_ready,
    output tx_byte, tx_send
  );

  modport slave (
    output rx_ready, rx_byte, rx_parity_err, rx_frame_err, tx_busy, tx_ready,
    input  tx_byte, tx_send
  );
endinterface

// File: rtl/uart_cfg_rx.sv
// UART receiver: 2-flop synchroniser, start-bit glitch filter, mid-bit
// sampling FSM, parity and framing error flags.
module uart_cfg_rx
  import uart_cfg_pkg::*;
#(
  parameter int CLK_HZ    = 25000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clock25,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int               DIVISOR  = divisor(CLK_HZ, BAUD);
  localparam int               CNT_W    = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rx_meta_r;
  logic                 rxs_r;
  logic                 rxs_prev_r;
  rx_state_t            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           bit_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 par_err_r;
  logic                 rx_ready_r;
  logic [DATA_BITS-1:0] rx_byte_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic [7:0]           data_ext_s;

  // Zero-extend the shift register so the shared parity helper can be used.
  always_comb begin
    data_ext_s                = 8'h00;
    data_ext_s[DATA_BITS-1:0] = shreg_r;
  end

  // Synchronise the asynchronous line and keep one older sample for edge detect;
  // reset to the idle-high level so reset release never looks like a start bit.
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r  <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      rx_meta_r  <= rx;
      rxs_r      <= rx_meta_r;
      rxs_prev_r <= rxs_r;
    end
  end

  // Receive FSM; a falling edge (not a low level) arms a frame, so after a
  // framing error the line must return high before the next start is seen.
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= RX_IDLE;
      cnt_r        <= '0;
      bit_r        <= 3'd0;
      shreg_r      <= '0;
      par_err_r    <= 1'b0;
      rx_ready_r   <= 1'b0;
      rx_byte_r    <= '0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rx_ready_r <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (rxs_prev_r && !rxs_r) begin
            cnt_r   <= '0;
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= '0;
            if (rxs_r) begin
              state_r <= RX_IDLE;
            end else begin
              bit_r     <= 3'd0;
              par_err_r <= 1'b0;
              state_r   <= RX_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            shreg_r <= {rxs_r, shreg_r[DATA_BITS-1:1]};
            if (bit_r == BIT_LAST) begin
              state_r <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= '0;
            par_err_r <= parity_bit(data_ext_s, PARITY) ^ rxs_r;
            state_r   <= RX_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r        <= '0;
            rx_byte_r    <= shreg_r;
            parity_err_r <= par_err_r;
            frame_err_r  <= ~rxs_r;
            rx_ready_r   <= 1'b1;
            state_r      <= RX_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= RX_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign rx_ready      = rx_ready_r;
  assign rx_byte       = rx_byte_r;
  assign rx_parity_err = parity_err_r;
  assign rx_frame_err  = frame_err_r;

endmodule

// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: transmitter FSM here, receiver in uart_cfg_rx.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLK_HZ    = 25000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clock25,
  input  logic       reset_n,
  input  logic       rx,
  output logic       tx,
  uart_cfg_if.slave  host
);

  localparam int               DIVISOR   = divisor(CLK_HZ, BAUD);
  localparam int               CNT_W     = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(DIVISOR - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           bit_r;
  logic                 stop_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 par_r;
  logic                 tx_r;
  logic                 busy_r;
  logic                 ready_r;
  logic [7:0]           tx_ext_s;

  uart_cfg_rx #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY)
  ) u_rx (
    .clock25      (clock25),
    .reset_n      (reset_n),
    .rx           (rx),
    .rx_ready     (host.rx_ready),
    .rx_byte      (host.rx_byte),
    .rx_parity_err(host.rx_parity_err),
    .rx_frame_err (host.rx_frame_err)
  );

  // Zero-extend the requested word for the shared parity helper.
  always_comb begin
    tx_ext_s                = 8'h00;
    tx_ext_s[DATA_BITS-1:0] = host.tx_byte;
  end

  // Transmit FSM; tx_ready is raised one cycle early so that it lands on the
  // final cycle of the last stop bit, and busy drops on the edge after it.
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= TX_IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      stop_r  <= 1'b0;
      shreg_r <= '0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          tx_r    <= 1'b1;
          ready_r <= 1'b0;
          if (host.tx_send) begin
            shreg_r <= host.tx_byte;
            par_r   <= parity_bit(tx_ext_s, PARITY);
            cnt_r   <= '0;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            tx_r    <= shreg_r[0];
            state_r <= TX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (bit_r == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                tx_r    <= par_r;
                state_r <= TX_PARITY;
              end else begin
                tx_r    <= 1'b1;
                stop_r  <= 1'b0;
                state_r <= TX_STOP;
              end
            end else begin
              bit_r   <= bit_r + 3'd1;
              shreg_r <= {1'b0, shreg_r[DATA_BITS-1:1]};
              tx_r    <= shreg_r[1];
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        TX_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            tx_r    <= 1'b1;
            stop_r  <= 1'b0;
            state_r <= TX_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (stop_r == STOP_LAST) begin
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= TX_IDLE;
            end else begin
              stop_r <= stop_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if ((stop_r == STOP_LAST) && (cnt_r == CNT_PRE)) begin
              ready_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= TX_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx            = tx_r;
  assign host.tx_busy  = busy_r;
  assign host.tx_ready = ready_r;

endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: an 8N1 instance (TX checks, loopback, RX
// framing/glitch/reset cases) and a 7E1 instance (RX parity cases).
module tb_uart_cfg;

  localparam int D     = 217;        // 25 MHz / 115200, integer division
  localparam int FRAME = D * 10;     // 8N1 frame length in cycles

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  logic clock25 = 1'b0;
  logic reset_n = 1'b1;
  logic rx8_bb  = 1'b1;
  logic rx7_bb  = 1'b1;
  logic loop_en = 1'b0;
  logic tx8;
  logic tx7;
  logic rx8;

  int checks = 0;
  int errors = 0;

  rx_exp_t    q8[$];
  rx_exp_t    q7[$];
  logic [7:0] qtx[$];

  int rx8_done = 0;
  int rx7_done = 0;
  int tx8_done = 0;

  // TX monitor state
  int         ncyc       = 0;
  bit         mon_on     = 1'b0;
  int         mon_cnt    = 0;
  logic [9:0] mon_bits   = 10'h000;
  bit         busy_ok    = 1'b1;
  logic       tx_prev    = 1'b1;
  int         last_ready = 0;
  int         last_gap   = 0;

  uart_cfg_if #(.DATA_BITS(8)) h8 ();
  uart_cfg_if #(.DATA_BITS(7)) h7 ();

  assign rx8 = loop_en ? tx8 : rx8_bb;

  uart_cfg #(
    .CLK_HZ(25000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_dut8 (
    .clock25(clock25), .reset_n(reset_n), .rx(rx8), .tx(tx8), .host(h8.slave)
  );

  uart_cfg #(
    .CLK_HZ(25000000), .BAUD(115200), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
  ) u_dut7 (
    .clock25(clock25), .reset_n(reset_n), .rx(rx7_bb), .tx(tx7), .host(h7.slave)
  );

  always #20 clock25 = ~clock25;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put_bit(input bit sel7, input logic v);
    if (sel7) rx7_bb = v;
    else      rx8_bb = v;
    repeat (D) @(posedge clock25);
    #1;
  endtask

  // Drive one serial frame; par < 0 means no parity bit. Line is left at stop_b.
  task automatic drive_rx(input bit sel7, input logic [7:0] data, input int nbits,
                          input int par, input logic stop_b);
    put_bit(sel7, 1'b0);
    for (int i = 0; i < nbits; i++) put_bit(sel7, data[i]);
    if (par >= 0) put_bit(sel7, par[0]);
    put_bit(sel7, stop_b);
  endtask

  task automatic wait_rx8(input int target);
    for (int i = 0; i < 3 * FRAME && rx8_done < target; i++) @(negedge clock25);
    check("rx8_count", rx8_done, target);
  endtask

  task automatic wait_rx7(input int target);
    for (int i = 0; i < 3 * FRAME && rx7_done < target; i++) @(negedge clock25);
    check("rx7_count", rx7_done, target);
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 3 * FRAME && tx8_done < target; i++) @(negedge clock25);
    check("tx_count", tx8_done, target);
  endtask

  task automatic wait_busy(input logic lvl);
    for (int i = 0; i < 3 * FRAME && h8.tx_busy !== lvl; i++) @(negedge clock25);
    check("tx_busy_wait", h8.tx_busy, lvl);
  endtask

  // RX scoreboard for the 8-bit instance.
  always @(negedge clock25) begin
    if (reset_n && h8.rx_ready) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx8_unexpected: got strobe byte %0h expected none", h8.rx_byte);
      end else begin
        rx_exp_t e;
        e = q8.pop_front();
        check("rx8_byte", h8.rx_byte, e.data);
        check("rx8_perr", h8.rx_parity_err, e.perr);
        check("rx8_ferr", h8.rx_frame_err, e.ferr);
      end
      rx8_done++;
    end
  end

  // RX scoreboard for the 7E1 instance.
  always @(negedge clock25) begin
    if (reset_n && h7.rx_ready) begin
      if (q7.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx7_unexpected: got strobe byte %0h expected none", h7.rx_byte);
      end else begin
        rx_exp_t e;
        e = q7.pop_front();
        check("rx7_byte", h7.rx_byte, e.data[6:0]);
        check("rx7_perr", h7.rx_parity_err, e.perr);
        check("rx7_ferr", h7.rx_frame_err, e.ferr);
      end
      rx7_done++;
    end
  end

  // TX monitor: decode the serial line mid-bit, time the frame, compare to queue.
  always @(negedge clock25) begin
    ncyc++;
    if (!reset_n) begin
      mon_on  = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (!mon_on) begin
        if (h8.tx_ready) begin
          checks++; errors++;
          $display("FAIL tx_unexpected_ready: got 1 expected 0");
        end
        if (tx_prev && !tx8) begin
          mon_on   = 1'b1;
          mon_cnt  = 0;
          mon_bits = 10'h000;
          busy_ok  = 1'b1;
          last_gap = ncyc - last_ready;
        end
      end
      if (mon_on) begin
        if (!h8.tx_busy) busy_ok = 1'b0;
        if ((mon_cnt % D) == (D / 2) && (mon_cnt / D) < 10) mon_bits[mon_cnt / D] = tx8;
        if (h8.tx_ready) begin
          check("tx_frame_len", mon_cnt + 1, FRAME);
          check("tx_busy_during", busy_ok, 1);
          if (qtx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected_frame: got bits %0h expected none", mon_bits);
          end else begin
            logic [7:0] e;
            e = qtx.pop_front();
            check("tx_bits", mon_bits, {1'b1, e, 1'b0});
          end
          tx8_done++;
          last_ready = ncyc;
          mon_on     = 1'b0;
        end else if (mon_cnt > FRAME + 100) begin
          checks++; errors++;
          $display("FAIL tx_timeout: got no tx_ready after %0d cycles expected %0d", mon_cnt, FRAME);
          mon_on = 1'b0;
        end
        mon_cnt++;
      end
      tx_prev = tx8;
    end
  end

  initial begin
    bit bad;
    h8.tx_send = 1'b0; h8.tx_byte = 8'h00;
    h7.tx_send = 1'b0; h7.tx_byte = 7'h00;
    #5 reset_n = 1'b0;
    repeat (4) @(negedge clock25);
    check("rst_tx",       tx8, 1);
    check("rst_busy",     h8.tx_busy, 0);
    check("rst_tx_ready", h8.tx_ready, 0);
    check("rst_rx_ready", h8.rx_ready, 0);
    check("rst_rx_byte",  h8.rx_byte, 0);
    check("rst_perr",     h8.rx_parity_err, 0);
    check("rst_ferr",     h8.rx_frame_err, 0);
    @(posedge clock25); #1 reset_n = 1'b1;
    repeat (5) @(posedge clock25); #1;

    // 1: single 0xA5 frame, tx low and busy high the cycle after accept
    qtx.push_back(8'hA5);
    h8.tx_byte = 8'hA5; h8.tx_send = 1'b1;
    @(posedge clock25); #1 h8.tx_send = 1'b0;
    @(negedge clock25);
    check("accept_tx_low", tx8, 0);
    check("accept_busy",   h8.tx_busy, 1);
    wait_tx(1);
    @(negedge clock25);
    check("busy_after_ready", h8.tx_busy, 0);
    repeat (20) @(posedge clock25); #1;

    // 2: loopback, tx_send held for two back-to-back frames
    loop_en = 1'b1;
    qtx.push_back(8'h3C); qtx.push_back(8'hC3);
    q8.push_back('{8'h3C, 1'b0, 1'b0});
    q8.push_back('{8'hC3, 1'b0, 1'b0});
    h8.tx_byte = 8'h3C; h8.tx_send = 1'b1;
    wait_busy(1'b1);
    h8.tx_byte = 8'hC3;
    wait_busy(1'b0);
    @(posedge clock25); #1;
    wait_busy(1'b1);
    h8.tx_send = 1'b0;
    wait_tx(3);
    check("b2b_gap", last_gap, 2);
    wait_rx8(2);
    repeat (50) @(posedge clock25); #1;
    loop_en = 1'b0;

    // 3: 7E1 parity, wrong then correct parity bit (0x55 has even ones -> p=0)
    q7.push_back('{8'h55, 1'b1, 1'b0});
    drive_rx(1'b1, 8'h55, 7, 1, 1'b1);
    wait_rx7(1);
    q7.push_back('{8'h55, 1'b0, 1'b0});
    drive_rx(1'b1, 8'h55, 7, 0, 1'b1);
    wait_rx7(2);

    // 4: framing error, line held low, then a good frame
    q8.push_back('{8'h81, 1'b0, 1'b1});
    drive_rx(1'b0, 8'h81, 8, -1, 1'b0);
    repeat (600) @(posedge clock25); #1;
    check("ferr_no_restart", rx8_done, 3);
    rx8_bb = 1'b1;
    repeat (300) @(posedge clock25); #1;
    q8.push_back('{8'h42, 1'b0, 1'b0});
    drive_rx(1'b0, 8'h42, 8, -1, 1'b1);
    wait_rx8(4);

    // 5: 50-cycle glitch rejected, then a valid 0x00 frame
    rx8_bb = 1'b0;
    repeat (50) @(posedge clock25); #1;
    rx8_bb = 1'b1;
    repeat (400) @(posedge clock25); #1;
    check("glitch_no_strobe", rx8_done, 4);
    q8.push_back('{8'h00, 1'b0, 1'b0});
    drive_rx(1'b0, 8'h00, 8, -1, 1'b1);
    wait_rx8(5);

    // 6: reset during TX data bit 3 and mid RX frame
    h8.tx_byte = 8'h96; h8.tx_send = 1'b1;
    @(posedge clock25); #1 h8.tx_send = 1'b0;
    rx8_bb = 1'b0;
    repeat (D * 4 + 50) @(posedge clock25); #1;
    check("pre_reset_busy", h8.tx_busy, 1);
    reset_n = 1'b0;
    @(negedge clock25);
    check("midrst_tx",   tx8, 1);
    check("midrst_busy", h8.tx_busy, 0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock25);
      if (h8.rx_ready || h8.tx_ready || !tx8 || h8.tx_busy) bad = 1'b1;
    end
    check("midrst_quiet", bad, 0);
    check("midrst_rx_byte", h8.rx_byte, 0);
    rx8_bb = 1'b1;
    @(posedge clock25); #1 reset_n = 1'b1;
    repeat (10) @(posedge clock25); #1;
    qtx.push_back(8'h5A);
    h8.tx_byte = 8'h5A; h8.tx_send = 1'b1;
    @(posedge clock25); #1 h8.tx_send = 1'b0;
    wait_tx(4);
    repeat (300) @(posedge clock25); #1;
    check("post_rst_rx_count", rx8_done, 5);

    check("q8_empty",  q8.size(), 0);
    check("q7_empty",  q7.size(), 0);
    check("qtx_empty", qtx.size(), 0);
    check("tx7_idle",  tx7, 1);
    check("busy7_idle", h7.tx_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
